// File: rtl/writeback_pipe.sv
// -----------------------------------------------------------------------------
// writeback_pipe
//
// Three-stage EX -> MEM -> WB register pipeline feeding the register-file
// write port. Loads (opcode 4'b1100) issue a read from the MEM stage and stall
// the front of the pipe until the read data arrives or a 15-cycle wait budget
// runs out. On timeout the load is dropped and MemErr pulses for one cycle.
//
// Ports
//   clk          : single clock, all state on its rising edge
//   rst          : synchronous active-high reset
//   IssueValid   : instruction presented this cycle
//   IssueOpCode  : opcode of the issued instruction
//   IssueRd      : destination register index
//   IssueRdEn    : instruction writes a register
//   AluResult    : ALU result or load address, valid with IssueValid
//   MemReq       : load read request (MEM stage holds a valid load)
//   MemAddr      : load address (MEM stage data)
//   MemAck       : read data valid this cycle
//   MemRData     : read data
//   Result       : register-file write data
//   RdIn         : register-file write index
//   RdEnIn       : register-file write enable
//   PipeHold     : upstream must hold issue; nothing is captured this cycle
//   MemErr       : one-cycle pulse after a load timeout
//
// Handshake: MemReq stays high, with MemAddr stable, until the cycle in which
// MemAck is seen high (the data in MemRData is taken at that rising edge) or
// the wait budget expires. MemAck while MemReq is low has no effect. Upstream
// treats PipeHold as ready=0: an instruction presented while PipeHold is high
// is not captured and must be presented again.
// -----------------------------------------------------------------------------
module writeback_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        IssueValid,
  input  logic [3:0]  IssueOpCode,
  input  logic [3:0]  IssueRd,
  input  logic        IssueRdEn,
  input  logic [31:0] AluResult,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic [31:0] Result,
  output logic [3:0]  RdIn,
  output logic        RdEnIn,
  output logic        PipeHold,
  output logic        MemErr
);

  localparam logic [3:0] OP_LOAD  = 4'b1100;
  localparam logic [3:0] WAIT_MAX = 4'd15;

  // EX and MEM carry the opcode; WB only keeps what the register file needs.
  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic        rd_en;
    logic [31:0] data;
  } stage_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  rd;
    logic        rd_en;
    logic [31:0] data;
  } wb_t;

  stage_t      ex_q;
  stage_t      mem_q;
  wb_t         wb_q;
  wb_t         wb_d;
  stage_t      issue_d;
  logic [3:0]  wait_cnt_q;
  logic        mem_err_q;
  logic        timeout;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  assign MemReq   = mem_q.valid && (mem_q.op == OP_LOAD);
  assign MemAddr  = mem_q.data;
  assign timeout  = MemReq && !MemAck && (wait_cnt_q == WAIT_MAX);
  assign PipeHold = MemReq && !MemAck && !timeout;

  // Fields are captured even for bubbles so that Rd/RdEn travel unchanged;
  // only the valid bit distinguishes a bubble.
  assign issue_d = '{valid: IssueValid,
                     op:    IssueOpCode,
                     rd:    IssueRd,
                     rd_en: IssueRdEn,
                     data:  AluResult};

  // Next WB contents. A stalled load sends a bubble; a timed-out load is
  // dropped entirely so no stale Rd/data reaches the register file.
  always_comb begin
    wb_d = '{valid: mem_q.valid,
             rd:    mem_q.rd,
             rd_en: mem_q.rd_en,
             data:  mem_q.data};
    if (MemReq) begin
      if (MemAck) begin
        wb_d.data = MemRData;
      end else begin
        wb_d = '0;
      end
    end
    if (PipeHold) begin
      wb_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q <= wb_d;
      if (!PipeHold) begin
        ex_q  <= issue_d;
        mem_q <= ex_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load wait counter and error pulse
  // ---------------------------------------------------------------------------
  // The counter only runs while stalled; any cycle that lets MEM advance
  // (no load, ack, or timeout) returns it to zero for the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      if (PipeHold) begin
        wait_cnt_q <= wait_cnt_q + 4'd1;
      end else begin
        wait_cnt_q <= '0;
      end
      mem_err_q <= timeout;
    end
  end

  // ---------------------------------------------------------------------------
  // Register-file write port, straight from WB
  // ---------------------------------------------------------------------------
  assign RdEnIn = wb_q.valid && wb_q.rd_en;
  assign RdIn   = wb_q.rd;
  assign Result = wb_q.data;
  assign MemErr = mem_err_q;

endmodule
